// File: rtl/led_pattern_ctrl_pkg.sv
// led_pattern_ctrl_pkg: colour/mode codes, switch bit positions and colour sequencing
package led_pattern_ctrl_pkg;
  localparam logic [1:0] COLOR_RED = 2'd0, COLOR_GREEN = 2'd1, COLOR_BLUE = 2'd2;
  localparam logic [1:0] MODE_SHIFT = 2'd0, MODE_FLASH = 2'd1, MODE_PINGPONG = 2'd2, MODE_HOLD = 2'd3;
  localparam int SW_EN = 0, SW_MODE_LO = 1, SW_DIR = 3;
  function automatic logic [1:0] next_color(input logic [1:0] c);
    return c == COLOR_RED ? COLOR_GREEN : c == COLOR_GREEN ? COLOR_BLUE : COLOR_RED;
  endfunction
endpackage

// File: rtl/led_pattern_ctrl_tick_gen.sv
// tick_gen: prescaler strobing tick once every COUNT_MAX+1 enabled cycles
module tick_gen #(
  parameter int NB_COUNTER = 14,
  parameter int COUNT_MAX = 5000
) (
  input  logic clock,
  input  logic i_reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  logic [NB_COUNTER-1:0] cnt;
  assign tick = enable && cnt == NB_COUNTER'(COUNT_MAX);
  always_ff @(posedge clock or posedge i_reset)
    if (i_reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: switch-driven LED pattern engine with RED->GREEN->BLUE colour sequencing
// Define LED_SW_SYNC_EN to pass i_sw through a two-flop synchronizer (adds 2 cycles latency).
module led_pattern_ctrl
  import led_pattern_ctrl_pkg::*;
#(
  parameter int NB_LEDS = 4,
  parameter int NB_SW = 4,
  parameter int NB_COUNTER = 14,
  parameter int COUNT_MAX = 5000
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_SW-1:0]   i_sw,
  output logic [NB_LEDS-1:0] o_led,
  output logic [NB_LEDS-1:0] o_led_g,
  output logic [NB_LEDS-1:0] o_led_b,
  output logic               o_tick,
  output logic [1:0]         o_color
);
  logic [NB_SW-1:0] sw;
  logic [1:0] mode, prev_mode, color;
  logic [NB_LEDS-1:0] pat, pat_n;
  logic dir, dir_n, adv, tick, mode_chg, step;
`ifdef LED_SW_SYNC_EN
  logic [NB_SW-1:0] sw_m;
  always_ff @(posedge clock or posedge i_reset)
    if (i_reset) begin
      sw_m <= '0;
      sw <= '0;
    end else begin
      sw_m <= i_sw;
      sw <= sw_m;
    end
`else
  assign sw = i_sw;
`endif
  assign mode = sw[SW_MODE_LO +: 2];
  assign mode_chg = mode != prev_mode;
  assign step = tick && !mode_chg;
  tick_gen #(.NB_COUNTER(NB_COUNTER), .COUNT_MAX(COUNT_MAX)) u_tick_gen (
    .clock(clock), .i_reset(i_reset), .enable(sw[SW_EN]), .clear(mode_chg), .tick(tick)
  );
  // dir is only meaningful in PINGPONG; SHIFT takes its direction straight from the switch
  always_comb begin
    pat_n = pat;
    dir_n = dir;
    adv = 1'b0;
    if (mode == MODE_SHIFT) begin
      pat_n = sw[SW_DIR] ? {pat[0], pat[NB_LEDS-1:1]} : {pat[NB_LEDS-2:0], pat[NB_LEDS-1]};
      adv = sw[SW_DIR] ? pat[0] : pat[NB_LEDS-1];
    end else if (mode == MODE_FLASH) begin
      pat_n = &pat ? '0 : '1;
      adv = &pat;
    end else if (mode == MODE_PINGPONG) begin
      pat_n = (dir ? pat[0] : !pat[NB_LEDS-1]) ? pat << 1 : pat >> 1;
      dir_n = dir ? !pat[0] : pat[NB_LEDS-1];
      adv = dir && pat[0];
    end
  end
  always_ff @(posedge clock or posedge i_reset)
    if (i_reset) begin
      pat <= NB_LEDS'(1);
      dir <= 1'b0;
      color <= COLOR_RED;
      prev_mode <= MODE_SHIFT;
      o_tick <= 1'b0;
    end else begin
      prev_mode <= mode;
      o_tick <= step;
      pat <= mode_chg ? NB_LEDS'(1) : step ? pat_n : pat;
      dir <= mode_chg ? 1'b0 : step ? dir_n : dir;
      color <= color > COLOR_BLUE ? COLOR_RED : step && adv ? next_color(color) : color;
    end
  assign o_led = color == COLOR_RED ? pat : '0;
  assign o_led_g = color == COLOR_GREEN ? pat : '0;
  assign o_led_b = color == COLOR_BLUE ? pat : '0;
  assign o_color = color;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed checks of prescaler, patterns, colour sequencing and reset
module tb_led_pattern_ctrl;
  logic clock = 1'b0;
  logic i_reset;
  logic [3:0] i_sw;
  logic [3:0] o_led, o_led_g, o_led_b;
  logic o_tick;
  logic [1:0] o_color;
  int vectors = 0;
  int errs = 0;
  int tick_seen;
  logic [3:0] pp_seq [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

  led_pattern_ctrl #(.NB_LEDS(4), .NB_SW(4), .NB_COUNTER(4), .COUNT_MAX(3)) dut (
    .clock(clock), .i_reset(i_reset), .i_sw(i_sw), .o_led(o_led), .o_led_g(o_led_g),
    .o_led_b(o_led_b), .o_tick(o_tick), .o_color(o_color)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_sw = 4'b0000;
    step(2);
    chk("rst_led", o_led, 4'b0001);
    chk("rst_led_g", o_led_g, 4'b0000);
    chk("rst_led_b", o_led_b, 4'b0000);
    chk("rst_color", {2'b00, o_color}, 4'd0);
    chk("rst_tick", {3'b000, o_tick}, 4'd0);
    // SHIFT left, red bank
    i_reset = 1'b0;
    i_sw = 4'b0001;
    step(3);
    chk("sh_pre_tick", {3'b000, o_tick}, 4'd0);
    chk("sh_pre_led", o_led, 4'b0001);
    step(1);
    chk("sh_tick1", {3'b000, o_tick}, 4'd1);
    chk("sh_led1", o_led, 4'b0010);
    step(1);
    chk("sh_tick_pulse", {3'b000, o_tick}, 4'd0);
    step(3);
    chk("sh_led2", o_led, 4'b0100);
    step(4);
    chk("sh_led3", o_led, 4'b1000);
    step(4);
    chk("sh_wrap_led", o_led, 4'b0000);
    chk("sh_wrap_g", o_led_g, 4'b0001);
    chk("sh_wrap_color", {2'b00, o_color}, 4'd1);
    // asynchronous reset mid-run
    i_reset = 1'b1;
    i_sw = 4'b1001;
    #1;
    chk("arst_led", o_led, 4'b0001);
    chk("arst_g", o_led_g, 4'b0000);
    chk("arst_color", {2'b00, o_color}, 4'd0);
    step(1);
    i_reset = 1'b0;
    // SHIFT right
    step(4);
    chk("shr_g1", o_led_g, 4'b1000);
    chk("shr_led1", o_led, 4'b0000);
    chk("shr_color", {2'b00, o_color}, 4'd1);
    step(4);
    chk("shr_g2", o_led_g, 4'b0100);
    step(4);
    chk("shr_g3", o_led_g, 4'b0010);
    // FLASH: mode change reloads pattern and counter
    step(2);
    i_sw = 4'b0011;
    step(1);
    chk("fl_reload", o_led_g, 4'b0001);
    chk("fl_reload_tick", {3'b000, o_tick}, 4'd0);
    step(3);
    chk("fl_wait", o_led_g, 4'b0001);
    step(1);
    chk("fl_ones", o_led_g, 4'b1111);
    step(4);
    chk("fl_zero_g", o_led_g, 4'b0000);
    chk("fl_color", {2'b00, o_color}, 4'd2);
    // PINGPONG entered on the cycle a tick was due: tick is dropped
    step(3);
    i_sw = 4'b0101;
    step(1);
    chk("pp_drop_tick", {3'b000, o_tick}, 4'd0);
    chk("pp_reload", o_led_b, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      step(4);
      chk($sformatf("pp_seq%0d", i), o_led_b, pp_seq[i]);
    end
    step(4);
    chk("pp_adv_led", o_led, 4'b0010);
    chk("pp_adv_b", o_led_b, 4'b0000);
    chk("pp_adv_color", {2'b00, o_color}, 4'd0);
    // disable holds everything, counter resumes from held value
    i_sw = 4'b0001;
    step(1);
    chk("hold_reload", o_led, 4'b0001);
    step(2);
    i_sw = 4'b0000;
    tick_seen = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      tick_seen += int'(o_tick);
    end
    chk("hold_ticks", 4'(tick_seen), 4'd0);
    chk("hold_led", o_led, 4'b0001);
    chk("hold_color", {2'b00, o_color}, 4'd0);
    i_sw = 4'b0001;
    step(1);
    chk("resume_pre", {3'b000, o_tick}, 4'd0);
    step(1);
    chk("resume_tick", {3'b000, o_tick}, 4'd1);
    chk("resume_led", o_led, 4'b0010);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
